fetch_sequencer: RTL and testbench

Fetch/execute controller and memory-port scheduler for the S-Machine CPU. It owns the program counter, fetches 16-bit instructions from the single-port program/data memory, and issues each one to the instruction interpreter with a one-cycle enable pulse. It time-multiplexes the memory port between instruction fetch and the interpreter's data accesses, and provides run, single-step, halt and execute-timeout control.

---
 rtl/fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Fetch/execute controller and memory-port scheduler for the S-Machine CPU.
// Owns the program counter, fetches 16-bit instructions from the shared
// single-port program/data memory and hands each one to the instruction
// interpreter with a one-cycle enable pulse. While the interpreter executes,
// the memory port belongs to the interpreter. At all other times the sequencer
// owns the port and never writes through it.
//
// Parameters
//   RESET_PC     program counter value after reset
//   HALT_OPCODE  inst[15:12] value that halts the sequencer without executing
//   MAX_EXEC     EXEC cycles allowed before a fault is raised (1..255)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   run, step           continuous-run level, single-step pulse (IDLE only)
//   halted, fault       sticky status flags, cleared only by reset
//   pc, icount          program counter, retired-instruction counter
//   mem_addr/wdata/we   memory request port
//   mem_rdata           memory read data, valid one cycle after the address
//   ii_inst, ii_enable  latched instruction and first-EXEC-cycle pulse
//   ii_addr/wdata/we    interpreter data request, honoured only in EXEC
//   ii_rdata            memory read data forwarded to the interpreter
//   ii_done, ii_pc      interpreter completion and the next pc it supplies
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned MAX_EXEC    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  output logic        halted,
  output logic        fault,
  output logic [7:0]  pc,
  output logic [15:0] icount,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ii_inst,
  output logic        ii_enable,
  input  logic [7:0]  ii_addr,
  input  logic [15:0] ii_wdata,
  input  logic        ii_we,
  output logic [15:0] ii_rdata,
  input  logic        ii_done,
  input  logic [7:0]  ii_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } state_t;

  // The timeout counter holds (EXEC cycles already spent) during an EXEC
  // cycle, so the last permitted cycle is the one where it equals MAX_EXEC-1.
  localparam logic [7:0] LAST_EXEC = 8'(MAX_EXEC - 1);

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_pc;
  logic [15:0] r_icount;
  logic [15:0] r_inst;
  logic        r_enable;
  logic        r_halted;
  logic        r_fault;
  logic        r_stepMode;
  logic [7:0]  r_execCnt;

  logic        w_isHalt;
  logic        w_timeout;
  logic        w_latch;
  logic        w_startExec;
  logic        w_retire;
  logic        w_setStepMode;
  logic        w_clrStepMode;
  logic        w_setHalt;
  logic        w_setFault;

  // Decode of the word arriving from memory during LATCH, and the
  // "this is the final allowed EXEC cycle" condition.
  assign w_isHalt  = (mem_rdata[15:12] == HALT_OPCODE);
  assign w_timeout = (r_execCnt == LAST_EXEC);

  // The sequencer only holds its state register here; every decision about
  // where to go next lives in the combinational block below.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and memory-port steering. The port is handed to the
  // interpreter only in EXEC, so a stray ii_we during fetch or idle can never
  // reach memory. Outside EXEC the write data bus is parked at zero. LATCH
  // keeps presenting pc so the address is stable across the read. When
  // ii_done and the timeout coincide, the done branch is taken first, so the
  // instruction retires normally.
  always_comb begin
    w_nextState   = r_state;
    w_latch       = 1'b0;
    w_startExec   = 1'b0;
    w_retire      = 1'b0;
    w_setStepMode = 1'b0;
    w_clrStepMode = 1'b0;
    w_setHalt     = 1'b0;
    w_setFault    = 1'b0;
    mem_addr      = 8'h00;
    mem_wdata     = 16'h0000;
    mem_we        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_nextState = S_FETCH;
        end else if (step) begin
          w_setStepMode = 1'b1;
          w_nextState   = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_addr    = r_pc;
        w_nextState = S_LATCH;
      end

      S_LATCH: begin
        mem_addr = r_pc;
        w_latch  = 1'b1;
        if (w_isHalt) begin
          w_setHalt   = 1'b1;
          w_nextState = S_HALTED;
        end else begin
          w_startExec = 1'b1;
          w_nextState = S_EXEC;
        end
      end

      S_EXEC: begin
        mem_addr  = ii_addr;
        mem_wdata = ii_wdata;
        mem_we    = ii_we;
        if (ii_done) begin
          w_retire = 1'b1;
          if (r_stepMode || !run) begin
            w_clrStepMode = 1'b1;
            w_nextState   = S_IDLE;
          end else begin
            w_nextState = S_FETCH;
          end
        end else if (w_timeout) begin
          w_setFault  = 1'b1;
          w_nextState = S_FAULT;
        end
      end

      S_HALTED: begin
        w_nextState = S_HALTED;
      end

      S_FAULT: begin
        w_nextState = S_FAULT;
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Architectural state: pc, retired count, latched instruction, the enable
  // pulse, sticky status flags, step mode and the execute timeout counter.
  // The enable pulse is registered from the LATCH->EXEC transition, so it is
  // high exactly for the first EXEC cycle. pc and icount move only when an
  // instruction retires, so a halt or a timeout leaves both untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_icount   <= 16'h0000;
      r_inst     <= 16'h0000;
      r_enable   <= 1'b0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
      r_stepMode <= 1'b0;
      r_execCnt  <= 8'h00;
    end else begin
      r_enable <= w_startExec;

      if (w_latch) begin
        r_inst <= mem_rdata;
      end

      if (w_latch) begin
        r_execCnt <= 8'h00;
      end else if (r_state == S_EXEC) begin
        r_execCnt <= r_execCnt + 8'h01;
      end

      if (w_retire) begin
        r_pc     <= ii_pc;
        r_icount <= r_icount + 16'h0001;
      end

      if (w_setStepMode) begin
        r_stepMode <= 1'b1;
      end else if (w_clrStepMode) begin
        r_stepMode <= 1'b0;
      end

      if (w_setHalt) begin
        r_halted <= 1'b1;
      end

      if (w_setFault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign pc        = r_pc;
  assign icount    = r_icount;
  assign ii_inst   = r_inst;
  assign ii_enable = r_enable;
  assign halted    = r_halted;
  assign fault     = r_fault;
  assign ii_rdata  = mem_rdata;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. It contains a behavioural memory,
// an interpreter responder, and a program-walking reference model that
// predicts the instruction stream, pc, icount and data writes of randomly
// generated programs.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int         MAX_EXEC = 16;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic        halted;
  logic        fault;
  logic [7:0]  pc;
  logic [15:0] icount;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [15:0] ii_inst;
  logic        ii_enable;
  logic [7:0]  ii_addr;
  logic [15:0] ii_wdata;
  logic        ii_we;
  logic [15:0] ii_rdata;
  logic        ii_done;
  logic [7:0]  ii_pc;

  fetch_sequencer #(
    .RESET_PC   (RESET_PC),
    .HALT_OPCODE(4'hF),
    .MAX_EXEC   (MAX_EXEC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .halted   (halted),
    .fault    (fault),
    .pc       (pc),
    .icount   (icount),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .ii_inst  (ii_inst),
    .ii_enable(ii_enable),
    .ii_addr  (ii_addr),
    .ii_wdata (ii_wdata),
    .ii_we    (ii_we),
    .ii_rdata (ii_rdata),
    .ii_done  (ii_done),
    .ii_pc    (ii_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory with a back-door loader for the bench.
  logic [15:0] mem [0:255];
  logic        ldEn;
  logic        ldClr;
  logic [7:0]  ldAddr;
  logic [15:0] ldData;

  always @(posedge clk) begin
    if (ldClr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (ldEn) begin
      mem[ldAddr] <= ldData;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Interpreter responder. In random mode the instruction encodes its own
  // behaviour: [11:4] next pc, [2] write ~inst to {4'hC,inst[7:4]} in the
  // first EXEC cycle, [1:0] cycles from enable to done. In directed mode the
  // next pc is pc+1, the delay is cfgDelay and cfgWrite drives BEEF to 8'h40
  // on every EXEC cycle and DEAD for one cycle after done.
  logic        cfgRandom;
  logic        cfgNever;
  logic        cfgWrite;
  int          cfgDelay;
  logic        busy;
  logic        linger;
  int          cnt;
  logic [15:0] curInst;
  logic [7:0]  curPc;

  always @(negedge clk) begin
    int          delay;
    logic        doWr;
    logic [7:0]  wa;
    logic [7:0]  np;
    logic [15:0] wd;
    ii_done  = 1'b0;
    ii_we    = 1'b0;
    ii_addr  = 8'h00;
    ii_wdata = 16'h0000;
    ii_pc    = 8'h00;
    if (reset) begin
      busy   = 1'b0;
      linger = 1'b0;
      cnt    = 0;
    end else begin
      if (linger) begin
        ii_we    = 1'b1;
        ii_addr  = 8'h40;
        ii_wdata = 16'hDEAD;
        linger   = 1'b0;
      end
      if (ii_enable) begin
        busy    = 1'b1;
        cnt     = 0;
        curInst = ii_inst;
        curPc   = pc;
      end else if (busy) begin
        cnt++;
      end
      if (busy) begin
        if (cfgRandom) begin
          delay = int'(curInst[1:0]);
          doWr  = curInst[2] && (cnt == 0);
          wa    = {4'hC, curInst[7:4]};
          wd    = ~curInst;
          np    = curInst[11:4];
        end else begin
          delay = cfgDelay;
          doWr  = cfgWrite;
          wa    = 8'h40;
          wd    = 16'hBEEF;
          np    = curPc + 8'd1;
        end
        if (doWr) begin
          ii_we    = 1'b1;
          ii_addr  = wa;
          ii_wdata = wd;
        end
        if (!cfgNever && cnt == delay) begin
          ii_done = 1'b1;
          ii_pc   = np;
          busy    = 1'b0;
          if (!cfgRandom && cfgWrite) linger = 1'b1;
        end
      end
    end
  end

  int passCount;
  int failCount;
  int checkCount;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge; all driving and sampling
  // happens there, well away from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic runVal, input logic stepVal);
    run  = runVal;
    step = stepVal;
    tick();
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [15:0] d);
    ldEn   = 1'b1;
    ldAddr = a;
    ldData = d;
    tick();
    ldEn   = 1'b0;
  endtask

  task automatic waitEnable(input string tag, input int budget);
    for (int i = 0; i < budget && !ii_enable; i++) tick();
    checkOutput(tag, 32'(ii_enable), 32'd1);
  endtask

  // Reference-model storage for random programs.
  logic [15:0] prog [32];
  logic [15:0] expInst [32];
  logic [7:0]  expPc [32];
  logic [15:0] expData [16];

  initial begin
    int          enCount;
    int          enCycle [4];
    logic [15:0] seen [4];
    int          weSeen;
    int          n;

    passCount = 0; failCount = 0; checkCount = 0;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    ldEn = 1'b0; ldClr = 1'b0; ldAddr = 8'h00; ldData = 16'h0000;
    cfgRandom = 1'b0; cfgNever = 1'b0; cfgWrite = 1'b0; cfgDelay = 1;

    // ---- Reset and idle ----
    ldClr = 1'b1;
    tick();
    ldClr = 1'b0;
    loadWord(8'h00, 16'h0401);
    loadWord(8'h01, 16'h0C01);
    loadWord(8'h02, 16'hF000);
    tick();
    reset = 1'b0;
    checkOutput("rst pc", 32'(pc), 32'(RESET_PC));
    checkOutput("rst icount", 32'(icount), 32'd0);
    checkOutput("rst halted", 32'(halted), 32'd0);
    checkOutput("rst fault", 32'(fault), 32'd0);
    checkOutput("rst ii_enable", 32'(ii_enable), 32'd0);
    checkOutput("rst ii_inst", 32'(ii_inst), 32'd0);
    checkOutput("rst mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst mem_wdata", 32'(mem_wdata), 32'd0);
    weSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_we) weSeen++;
    end
    checkOutput("idle mem_we cycles", 32'(weSeen), 32'd0);
    checkOutput("idle pc", 32'(pc), 32'd0);

    // ---- Continuous run to a halt ----
    run = 1'b1;
    enCount = 0;
    for (int c = 0; c < 40 && !halted; c++) begin
      tick();
      if (ii_enable) begin
        if (enCount < 4) begin
          seen[enCount]    = ii_inst;
          enCycle[enCount] = c;
        end
        enCount++;
      end
    end
    checkOutput("run enables", 32'(enCount), 32'd2);
    checkOutput("run inst0", 32'(seen[0]), 32'h0401);
    checkOutput("run inst1", 32'(seen[1]), 32'h0C01);
    checkOutput("run fetch latency", 32'(enCycle[0]), 32'd2);
    checkOutput("run period", 32'(enCycle[1] - enCycle[0]), 32'd4);
    checkOutput("run halted", 32'(halted), 32'd1);
    checkOutput("run halt pc", 32'(pc), 32'h02);
    checkOutput("run icount", 32'(icount), 32'd2);
    checkOutput("run halt inst", 32'(ii_inst), 32'hF000);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    step = 1'b0;
    enCount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ii_enable) enCount++;
    end
    checkOutput("halted enables", 32'(enCount), 32'd0);
    checkOutput("halted sticky", 32'(halted), 32'd1);
    checkOutput("halted pc", 32'(pc), 32'h02);
    checkOutput("halted icount", 32'(icount), 32'd2);

    // ---- Single step ----
    reset = 1'b1; run = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checkOutput("reset clears halted", 32'(halted), 32'd0);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b0, 1'b1);
      step = 1'b0;
      enCount = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (ii_enable) begin
          if (enCount < 4) begin
            seen[enCount]    = ii_inst;
            enCycle[enCount] = c;
          end
          enCount++;
        end
      end
      checkOutput("step enables", 32'(enCount), 32'd1);
      checkOutput("step latency", 32'(enCycle[0]), 32'd1);
      checkOutput("step inst", 32'(seen[0]), (s == 0) ? 32'h0401 : 32'h0C01);
      checkOutput("step pc", 32'(pc), 32'(s + 1));
      checkOutput("step icount", 32'(icount), 32'(s + 1));
      checkOutput("step halted", 32'(halted), 32'd0);
    end

    // ---- Data access arbitration ----
    reset = 1'b1;
    loadWord(8'h00, 16'h1234);
    loadWord(8'h01, 16'hF000);
    loadWord(8'h40, 16'h0000);
    reset = 1'b0;
    cfgWrite = 1'b1; cfgDelay = 1;
    run = 1'b1;
    waitEnable("arb enable", 10);
    checkOutput("arb exec mem_we", 32'(mem_we), 32'd1);
    checkOutput("arb exec mem_addr", 32'(mem_addr), 32'h40);
    checkOutput("arb exec mem_wdata", 32'(mem_wdata), 32'hBEEF);
    tick();
    checkOutput("arb done mem_we", 32'(mem_we), 32'd1);
    tick();
    checkOutput("arb fetch mem_addr", 32'(mem_addr), 32'h01);
    checkOutput("arb fetch mem_we", 32'(mem_we), 32'd0);
    checkOutput("arb fetch mem_wdata", 32'(mem_wdata), 32'd0);
    for (int i = 0; i < 20 && !halted; i++) tick();
    checkOutput("arb halted", 32'(halted), 32'd1);
    checkOutput("arb pc", 32'(pc), 32'h01);
    checkOutput("arb icount", 32'(icount), 32'd1);
    checkOutput("arb memory", 32'(mem[8'h40]), 32'hBEEF);
    cfgWrite = 1'b0;

    // ---- Execute timeout ----
    reset = 1'b1; run = 1'b0;
    loadWord(8'h01, 16'h5678);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1);
    step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("pre-timeout pc", 32'(pc), 32'h01);
    cfgNever = 1'b1;
    run = 1'b1;
    waitEnable("timeout enable", 10);
    n = 0;
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    checkOutput("timeout cycles", 32'(n), 32'(MAX_EXEC));
    checkOutput("timeout fault", 32'(fault), 32'd1);
    checkOutput("timeout pc", 32'(pc), 32'h01);
    checkOutput("timeout icount", 32'(icount), 32'd1);
    checkOutput("timeout halted", 32'(halted), 32'd0);
    cfgNever = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    step = 1'b0;
    enCount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ii_enable) enCount++;
    end
    checkOutput("fault enables", 32'(enCount), 32'd0);
    checkOutput("fault sticky", 32'(fault), 32'd1);
    checkOutput("fault pc", 32'(pc), 32'h01);
    checkOutput("fault icount", 32'(icount), 32'd1);

    // ---- Reset in the middle of EXEC with a live write ----
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checkOutput("reset clears fault", 32'(fault), 32'd0);
    applyStimulus(1'b0, 1'b1);
    step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("pre-reset pc", 32'(pc), 32'h01);
    cfgNever = 1'b1; cfgWrite = 1'b1;
    applyStimulus(1'b0, 1'b1);
    step = 1'b0;
    waitEnable("midreset enable", 10);
    checkOutput("midreset exec mem_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset mem_we", 32'(mem_we), 32'd0);
    checkOutput("midreset pc", 32'(pc), 32'(RESET_PC));
    checkOutput("midreset icount", 32'(icount), 32'd0);
    checkOutput("midreset ii_enable", 32'(ii_enable), 32'd0);
    checkOutput("midreset mem_addr", 32'(mem_addr), 32'd0);
    tick();
    reset = 1'b0;
    cfgNever = 1'b0; cfgWrite = 1'b0;

    // ---- Random programs against the reference model ----
    for (int it = 0; it < 3; it++) begin
      int          k;
      int          lastEn;
      logic [7:0]  pcm;
      for (int a = 0; a < 32; a++) begin
        if (a == 31 || $urandom_range(0, 7) == 0) begin
          prog[a] = {4'hF, 12'($urandom)};
        end else begin
          int np;
          int op;
          np = a + int'($urandom_range(1, 3));
          if (np > 31) np = 31;
          op = int'($urandom_range(0, 14));
          prog[a] = {4'(op), 8'(np), 1'($urandom), 1'($urandom), 2'($urandom)};
        end
      end
      for (int d = 0; d < 16; d++) expData[d] = 16'h0000;
      pcm = 8'h00;
      n = 0;
      while (prog[pcm[4:0]][15:12] != 4'hF) begin
        expInst[n] = prog[pcm[4:0]];
        expPc[n]   = pcm;
        if (prog[pcm[4:0]][2]) expData[prog[pcm[4:0]][7:4]] = ~prog[pcm[4:0]];
        pcm = prog[pcm[4:0]][11:4];
        n++;
      end

      reset = 1'b1; run = 1'b0;
      ldClr = 1'b1;
      tick();
      ldClr = 1'b0;
      for (int a = 0; a < 32; a++) loadWord(8'(a), prog[a]);
      reset = 1'b0;
      cfgRandom = 1'b1;
      run = 1'b1;
      k = 0;
      lastEn = 0;
      for (int c = 0; c < 400 && !halted; c++) begin
        tick();
        if (ii_enable) begin
          if (k < n) begin
            checkOutput("rand inst", 32'(ii_inst), 32'(expInst[k]));
            checkOutput("rand pc", 32'(pc), 32'(expPc[k]));
            if (k > 0) checkOutput("rand period", 32'(c - lastEn), 32'(3 + int'(expInst[k-1][1:0])));
          end
          lastEn = c;
          k++;
        end
      end
      checkOutput("rand halted", 32'(halted), 32'd1);
      checkOutput("rand count", 32'(k), 32'(n));
      checkOutput("rand halt pc", 32'(pc), 32'(pcm));
      checkOutput("rand icount", 32'(icount), 32'(n));
      checkOutput("rand fault", 32'(fault), 32'd0);
      for (int d = 0; d < 16; d++) checkOutput("rand data", 32'(mem[8'hC0 + 8'(d)]), 32'(expData[d]));
      run = 1'b0;
      cfgRandom = 1'b0;
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
